// File: rtl/qsn_pipe.sv
// Pipelined quasi-cyclic shift network. It rotates one LIFTING_FACTOR-bit circulant
// block per transfer. Two register stages with valid/ready flow control and a global
// advance. Out-of-range shifts are flagged and counted in a saturating counter.
module qsn_pipe #(
   parameter int unsigned LIFTING_FACTOR = 8,
   parameter int unsigned SHIFT_WIDTH    = $clog2(LIFTING_FACTOR),
   parameter int unsigned ERR_CNT_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LIFTING_FACTOR-1:0] in_data,
   input  logic [SHIFT_WIDTH-1:0]    in_shift,
   input  logic [1:0]                in_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LIFTING_FACTOR-1:0] out_data,
   output logic                      out_err,
   output logic [ERR_CNT_WIDTH-1:0]  err_count,
   input  logic                      err_clr
);

   localparam int unsigned SW1 = SHIFT_WIDTH + 1;
   // L needs one bit more than the shift field when L is a power of two
   localparam logic [SHIFT_WIDTH:0] LF = SW1'(LIFTING_FACTOR);

   localparam logic [1:0] MODE_ROT_R = 2'b00;
   localparam logic [1:0] MODE_ROT_L = 2'b01;
   localparam logic [1:0] MODE_BYP   = 2'b10;
   localparam logic [1:0] MODE_ZERO  = 2'b11;

   logic adv;
   logic in_fire;
   logic in_oor;

   logic                      s1_valid;
   logic [LIFTING_FACTOR-1:0] s1_data;
   logic [SHIFT_WIDTH-1:0]    s1_shift;
   logic [1:0]                s1_mode;
   logic                      s1_oor;

   logic [2*LIFTING_FACTOR-1:0] dbl;
   logic [SHIFT_WIDTH:0]        rot_base;
   logic [LIFTING_FACTOR-1:0]   rot_data;
   logic [LIFTING_FACTOR-1:0]   s2_data_d;

   // Both stages move together; a stalled output freezes the whole pipe
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign in_fire  = in_valid && adv;
   // Only the rotating modes care about the shift range
   assign in_oor   = !in_mode[1] && ({1'b0, in_shift} >= LF);

   // Stage 1: capture the raw transfer and its range flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_shift <= '0;
         s1_mode  <= MODE_ROT_R;
         s1_oor   <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data  <= in_data;
            s1_shift <= in_shift;
            s1_mode  <= in_mode;
            s1_oor   <= in_oor;
         end
      end
   end

   // Rotation by indexing the doubled block; base forced to 0 when the result is masked
   always_comb begin
      dbl      = {s1_data, s1_data};
      rot_base = '0;
      if (!s1_oor) begin
         case (s1_mode)
            MODE_ROT_R: rot_base = {1'b0, s1_shift};
            MODE_ROT_L: rot_base = LF - {1'b0, s1_shift};
            default:    rot_base = '0;
         endcase
      end
      rot_data = dbl[rot_base +: LIFTING_FACTOR];
   end

   // Result selection by mode
   always_comb begin
      s2_data_d = '0;
      unique case (s1_mode)
         MODE_ROT_R, MODE_ROT_L: s2_data_d = s1_oor ? '0 : rot_data;
         MODE_BYP:               s2_data_d = s1_data;
         MODE_ZERO:              s2_data_d = '0;
         default:                s2_data_d = '0;
      endcase
   end

   // Stage 2: registered result; data only reloads when a real transfer arrives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= s2_data_d;
            out_err  <= s1_oor;
         end
      end
   end

   // Saturating error counter, counted at input acceptance; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (in_fire && in_oor && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_qsn_pipe.sv
// Self-checking bench for qsn_pipe: an L=6 instance for range, flow control and counter
// behaviour, and an L=8 instance for the power-of-two rotation vectors.
module tb_qsn_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // L=6 instance
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_err_clr;
   logic [5:0] a_in_data, a_out_data;
   logic [2:0] a_in_shift;
   logic [1:0] a_in_mode;
   logic [7:0] a_err_count;

   // L=8 instance
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_err_clr;
   logic [7:0] b_in_data, b_out_data;
   logic [2:0] b_in_shift;
   logic [1:0] b_in_mode;
   logic [7:0] b_err_count;

   qsn_pipe #(.LIFTING_FACTOR(6), .SHIFT_WIDTH(3), .ERR_CNT_WIDTH(8)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_shift(a_in_shift), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_err(a_out_err), .err_count(a_err_count), .err_clr(a_err_clr)
   );

   qsn_pipe #(.LIFTING_FACTOR(8), .SHIFT_WIDTH(3), .ERR_CNT_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_shift(b_in_shift), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_err(b_out_err), .err_count(b_err_count), .err_clr(b_err_clr)
   );

   // Scoreboard for the L=6 instance: {err, data}
   logic [6:0] exp_q[$];
   logic [6:0] got_q[$];
   int         got_cyc[$];
   int         exp_cnt = 0;

   // Reference: O[i] = I[(i+s) mod l] for mode 0, I[(i-s) mod l] for mode 1
   function automatic logic [7:0] ref_rot(int l, logic [7:0] d, int s, int m);
      logic [7:0] r;
      r = '0;
      if (m == 3 || (m < 2 && s >= l)) return r;
      if (m == 2) return d;
      for (int i = 0; i < l; i++) begin
         if (m == 0) r[i] = d[(i + s) % l];
         else        r[i] = d[(i - s + l) % l];
      end
      return r;
   endfunction

   function automatic logic ref_err(int l, int s, int m);
      return (m < 2) && (s >= l);
   endfunction

   // Drive one cycle on the L=6 instance and log both sides of any handshake
   task automatic a_cycle(input logic v, input logic [5:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic ordy, input logic clr);
      logic [7:0] rr;
      logic       re;
      @(negedge clk);
      a_in_valid  = v;
      a_in_data   = d;
      a_in_shift  = s;
      a_in_mode   = m;
      a_out_ready = ordy;
      a_err_clr   = clr;
      #1;
      if (a_out_valid && a_out_ready) begin
         got_q.push_back({a_out_err, a_out_data});
         got_cyc.push_back(cyc);
      end
      rr = ref_rot(6, {2'b00, d}, int'(s), int'(m));
      re = ref_err(6, int'(s), int'(m));
      if (v && a_in_ready) exp_q.push_back({re, rr[5:0]});
      if (clr) exp_cnt = 0;
      else if (v && a_in_ready && re && exp_cnt < 255) exp_cnt = exp_cnt + 1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data !== 6'd0 || a_out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_out6: got v=%b d=%h e=%b expected 0/00/0",
                  a_out_valid, a_out_data, a_out_err);
      end
      checks++;
      if (a_err_count !== 8'd0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cnt6: got cnt=%0d rdy=%b expected 0/1", a_err_count, a_in_ready);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_out_data !== 8'd0 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_out8: got v=%b d=%h rdy=%b expected 0/00/1",
                  b_out_valid, b_out_data, b_in_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Power-of-two rotations with exact two-cycle latency
   task automatic test_rot8();
      logic [7:0] td[4] = '{8'h01, 8'h01, 8'h01, 8'h01};
      logic [2:0] ts[4] = '{3'd3, 3'd3, 3'd0, 3'd0};
      logic [1:0] tm[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
      logic [7:0] e;
      for (int k = 0; k < 4; k++) begin
         e = ref_rot(8, td[k], int'(ts[k]), int'(tm[k]));
         @(negedge clk);
         b_in_valid = 1'b1;
         b_in_data  = td[k];
         b_in_shift = ts[k];
         b_in_mode  = tm[k];
         @(negedge clk);
         b_in_valid = 1'b0;
         #1;
         checks++;
         if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rot8_early[%0d]: got out_valid=%b expected 0", k, b_out_valid);
         end
         @(negedge clk);
         #1;
         checks++;
         if (b_out_valid !== 1'b1 || b_out_data !== e || b_out_err !== 1'b0) begin
            errors++;
            $display("FAIL rot8[%0d]: got v=%b d=%h e=%b expected 1/%h/0",
                     k, b_out_valid, b_out_data, b_out_err, e);
         end
      end
   endtask

   // Non-power-of-two: in-range, out-of-range and bypass with large shift
   task automatic test_l6_directed();
      clear_sb();
      a_cycle(1'b1, 6'b000011, 3'd5, 2'd0, 1'b1, 1'b0);
      a_cycle(1'b1, 6'b000011, 3'd6, 2'd0, 1'b1, 1'b0);
      a_cycle(1'b1, 6'b101101, 3'd7, 2'd2, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (got_q.size() !== 3) begin
         errors++;
         $display("FAIL l6_count: got %0d results expected 3", got_q.size());
      end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL l6_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (a_err_count !== 8'd1 || exp_cnt != 1) begin
         errors++;
         $display("FAIL l6_err_count: got %0d expected 1 (model %0d)", a_err_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clear_sb();
      for (int k = 0; k < 16; k++)
         a_cycle(1'b1, 6'($urandom), 3'($urandom), 2'($urandom), 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (got_q.size() !== 16 || exp_q.size() !== 16) begin
         errors++;
         $display("FAIL b2b_count: got %0d results expected 16 (accepted %0d)",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      for (int i = 1; i < got_cyc.size(); i++) begin
         checks++;
         if (got_cyc[i] - got_cyc[i-1] !== 1) begin
            errors++;
            $display("FAIL b2b_rate[%0d]: got gap %0d expected 1", i,
                     got_cyc[i] - got_cyc[i-1]);
         end
      end
      checks++;
      if (a_err_count !== 8'(exp_cnt)) begin
         errors++;
         $display("FAIL b2b_err_count: got %0d expected %0d", a_err_count, exp_cnt);
      end
   endtask

   task automatic test_stall();
      logic [5:0] held;
      held = '0;
      clear_sb();
      a_cycle(1'b1, 6'($urandom), 3'($urandom_range(0, 5)), 2'($urandom), 1'b1, 1'b0);
      a_cycle(1'b1, 6'($urandom), 3'($urandom_range(0, 5)), 2'($urandom), 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         a_cycle(1'b1, 6'($urandom), 3'($urandom), 2'($urandom), 1'b0, 1'b0);
         checks++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready[%0d]: got v=%b rdy=%b expected 1/0",
                     k, a_out_valid, a_in_ready);
         end
         if (k > 0) begin
            checks++;
            if (a_out_data !== held) begin
               errors++;
               $display("FAIL stall_hold[%0d]: got %h expected %h", k, a_out_data, held);
            end
         end
         held = a_out_data;
      end
      for (int k = 0; k < 6; k++) a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (got_q.size() !== 2 || exp_q.size() !== 2) begin
         errors++;
         $display("FAIL stall_count: got %0d results expected 2 (accepted %0d)",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_saturate();
      int bad;
      bad = 0;
      clear_sb();
      for (int k = 0; k < 260; k++)
         a_cycle(1'b1, 6'($urandom), 3'($urandom_range(6, 7)), 2'($urandom_range(0, 1)),
                 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (a_err_count !== 8'd255 || exp_cnt != 255) begin
         errors++;
         $display("FAIL sat_count: got %0d expected 255 (model %0d)", a_err_count, exp_cnt);
      end
      checks++;
      if (got_q.size() !== 260) begin
         errors++;
         $display("FAIL sat_results: got %0d results expected 260", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sat_data: got %0d wrong results expected 0", bad);
      end
      a_cycle(1'b1, 6'h3f, 3'd6, 2'd1, 1'b1, 1'b1);
      a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (a_err_count !== 8'd0 || exp_cnt != 0) begin
         errors++;
         $display("FAIL clr_priority: got %0d expected 0", a_err_count);
      end
   endtask

   task automatic test_reset_midstream();
      logic [6:0] first;
      clear_sb();
      a_cycle(1'b1, 6'($urandom), 3'd6, 2'd0, 1'b1, 1'b0);
      a_cycle(1'b1, 6'($urandom), 3'd7, 2'd1, 1'b1, 1'b0);
      a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (a_out_valid !== 1'b1 || a_err_count !== 8'd2) begin
         errors++;
         $display("FAIL pre_reset: got v=%b cnt=%0d expected 1/2", a_out_valid, a_err_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_err_count !== 8'd0 || a_out_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b cnt=%0d e=%b expected 0/0/0",
                  a_out_valid, a_err_count, a_out_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      exp_cnt = 0;
      a_cycle(1'b1, 6'($urandom), 3'($urandom_range(0, 5)), 2'($urandom_range(0, 1)),
              1'b1, 1'b0);
      a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_early: got out_valid=%b expected 0", a_out_valid);
      end
      a_cycle(1'b0, 6'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      first = (exp_q.size() > 0) ? exp_q[0] : 7'h7f;
      checks++;
      if (a_out_valid !== 1'b1 || {a_out_err, a_out_data} !== first) begin
         errors++;
         $display("FAIL post_reset_latency: got v=%b data=%h expected 1/%h",
                  a_out_valid, {a_out_err, a_out_data}, first);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      a_in_valid = 1'b0; a_in_data = '0; a_in_shift = '0; a_in_mode = '0;
      a_out_ready = 1'b1; a_err_clr = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_shift = '0; b_in_mode = '0;
      b_out_ready = 1'b1; b_err_clr = 1'b0;
      test_reset();
      test_rot8();
      test_l6_directed();
      test_back_to_back();
      test_stall();
      test_saturate();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
